// File: rtl/logic_sweep_controller.sv
// Sweep sequencer for the Generator/Concat/Array_selector datapath: steps the address, captures results, hands them off on valid/ready.
// Optional build macro LOGIC_SWEEP_PARITY_EN adds the registered out_parity output.
module logic_sweep_controller #(
  parameter int SIZE = 16,
  parameter int K    = 8,
  localparam int AW  = $clog2(SIZE),
  localparam int KW  = $clog2(K),
  localparam int RW  = SIZE * KW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic [AW-1:0] addr_out,
  input  logic [RW-1:0] result_in,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [RW-1:0] out_data,
  output logic [AW-1:0] out_addr,
`ifdef LOGIC_SWEEP_PARITY_EN
  output logic          out_parity,
`endif
  output logic          done
);

  typedef enum logic [2:0] {IDLE, SETTLE, CAPTURE, PRESENT, FINISH} state_t;

  localparam logic [AW:0] SIZE_C = (AW+1)'(SIZE);

  state_t      state, state_nxt;
  logic [AW:0] remaining;
  logic        accept, capture, handshake;

  function automatic logic [AW:0] clamp_count(input logic [AW:0] c);
    return (c > SIZE_C) ? SIZE_C : c;
  endfunction

  assign accept    = (state == IDLE) && start && (count != '0);
  assign capture   = (state == CAPTURE);
  assign handshake = (state == PRESENT) && out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign done      = (state == FINISH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (count == '0) ? FINISH : SETTLE;
      SETTLE:  state_nxt = CAPTURE;
      CAPTURE: state_nxt = PRESENT;
      PRESENT: if (handshake) state_nxt = (remaining == (AW+1)'(1)) ? FINISH : SETTLE;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Address/count bookkeeping; the address only moves on a completed handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_out  <= '0;
      remaining <= '0;
    end else if (accept) begin
      addr_out  <= base_addr;
      remaining <= clamp_count(count);
    end else if (handshake) begin
      remaining <= remaining - (AW+1)'(1);
      if (remaining != (AW+1)'(1)) addr_out <= addr_out + AW'(1);
    end
  end

  // Output stage: capture after the settle cycle, hold until accepted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
    end else if (capture) begin
      out_valid <= 1'b1;
      out_data  <= result_in;
      out_addr  <= addr_out;
    end else if (handshake) begin
      out_valid <= 1'b0;
    end
  end

`ifdef LOGIC_SWEEP_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          out_parity <= 1'b0;
    else if (capture) out_parity <= ^result_in;
  end
`endif

endmodule
